mac_sched: RTL and testbench

MAC_SCHED -- requirements
Module: mac_sched

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_rr_arb.sv | 44 ++++
 rtl/mac_sched.sv | 122 ++++++++++++
 tb/tb_mac_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job scheduler: FSM encoding, default width
// and the index-width helper used by the scheduler and its arbiter.
package mac_pkg;

  localparam int DW_DEF = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around; returns both the one-hot pick and its index.
module mac_rr_arb
  import mac_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pick_idx
);

  int            j_s;
  logic [PW-1:0] j_idx_s;
  logic          found_s;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found_s  = 1'b0;
    j_s      = 0;
    j_idx_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j_s = int'(ptr) + k;
      if (j_s >= NREQ) begin
        j_s = j_s - NREQ;
      end else begin
        j_s = j_s;
      end
      j_idx_s = PW'(j_s);
      if (!found_s && req[j_idx_s]) begin
        found_s        = 1'b1;
        pick[j_idx_s]  = 1'b1;
        pick_idx       = j_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mac_sched.sv
// Job scheduler driving an external load/add accumulator: arbitrates requesters
// round-robin and sequences LOAD -> ADD -> STORE -> DONE for each accepted job.
module mac_sched
  import mac_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    result,
  output logic             busy,
  output logic             dp_load,
  output logic             dp_add,
  output logic [DW-1:0]    dp_din,
  input  logic [DW-1:0]    dp_acc
);

  localparam int PW = idx_w(NREQ);

  logic [2:0]      state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   w_r;
  logic [NREQ-1:0] w_oh_r;
  logic [DW-1:0]   a_r;
  logic [DW-1:0]   b_r;
  logic [DW-1:0]   result_r;
  logic [NREQ-1:0] pick_s;
  logic [PW-1:0]   pick_idx_s;

  mac_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_r),
    .pick     (pick_s),
    .pick_idx (pick_idx_s)
  );

  // FSM, round-robin pointer, latched job operands and the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ptr_r    <= '0;
      w_r      <= '0;
      w_oh_r   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
    end else if (ena) begin
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            a_r     <= req_a[int'(pick_idx_s)*DW +: DW];
            b_r     <= req_b[int'(pick_idx_s)*DW +: DW];
            w_r     <= pick_idx_s;
            w_oh_r  <= pick_s;
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD:  state_r <= ST_ADD;
        ST_ADD:   state_r <= ST_STORE;
        ST_STORE: begin
          result_r <= dp_acc;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          ptr_r   <= (w_r == PW'(NREQ-1)) ? '0 : w_r + PW'(1);
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode; every pulse is qualified by ena so a stall emits nothing.
  always_comb begin
    gnt     = '0;
    done    = '0;
    dp_load = 1'b0;
    dp_add  = 1'b0;
    dp_din  = '0;
    case (state_r)
      ST_LOAD: begin
        dp_din = a_r;
        if (ena) begin
          gnt     = w_oh_r;
          dp_load = 1'b1;
        end else begin
          gnt = '0;
        end
      end
      ST_ADD: begin
        dp_din = b_r;
        if (ena) begin
          dp_add = 1'b1;
        end else begin
          dp_add = 1'b0;
        end
      end
      ST_DONE: begin
        if (ena) begin
          done = w_oh_r;
        end else begin
          done = '0;
        end
      end
      default: dp_din = '0;
    endcase
  end

  assign busy   = (state_r != ST_IDLE);
  assign result = result_r;

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched with a behavioural load/add accumulator standing
// in for the datapath; expected values are hand-computed per vector.
module tb_mac_sched;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [1:0]  req;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  result;
  logic        busy;
  logic        dp_load;
  logic        dp_add;
  logic [7:0]  dp_din;
  logic [7:0]  acc_r;

  int checks   = 0;
  int failures = 0;
  int add_cnt  = 0;
  int done_cnt = 0;
  int gnt_cnt  = 0;
  int add_snap;

  mac_sched #(.DW(8), .NREQ(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .req_a   (req_a),
    .req_b   (req_b),
    .gnt     (gnt),
    .done    (done),
    .result  (result),
    .busy    (busy),
    .dp_load (dp_load),
    .dp_add  (dp_add),
    .dp_din  (dp_din),
    .dp_acc  (acc_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model plus pulse counters.
  always @(posedge clk) begin
    if (dp_load) acc_r <= dp_din;
    else if (dp_add) acc_r <= acc_r + dp_din;
    if (dp_add) add_cnt <= add_cnt + 1;
    if (done != 2'b00) done_cnt <= done_cnt + 1;
    if (gnt != 2'b00) gnt_cnt <= gnt_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the grant, then follows the job through to its done pulse.
  task automatic run_job(input string tag, input int idx, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] res,
                         input int exp_wait, input logic [1:0] req_after);
    int w;
    logic [1:0] oh;
    w  = 0;
    oh = 2'b01 << idx;
    while (gnt == 2'b00 && w < 8) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_wait"}, w, exp_wait);
    check_eq({tag, "_gnt"}, gnt, oh);
    check_eq({tag, "_load"}, dp_load, 1'b1);
    check_eq({tag, "_din_a"}, dp_din, a);
    req = req_after;
    @(negedge clk);
    check_eq({tag, "_add"}, dp_add, 1'b1);
    check_eq({tag, "_din_b"}, dp_din, b);
    check_eq({tag, "_gnt_off"}, gnt, 2'b00);
    @(negedge clk);
    check_eq({tag, "_store_nodone"}, done, 2'b00);
    check_eq({tag, "_busy"}, busy, 1'b1);
    @(negedge clk);
    check_eq({tag, "_done"}, done, oh);
    check_eq({tag, "_result"}, result, res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = 2'b11;
    req_a = 16'hFFFF;
    req_b = 16'hFFFF;
    #1;
    check_eq("rst_async_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_done", done, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_load", dp_load, 1'b0);
    check_eq("rst_add", dp_add, 1'b0);
    check_eq("rst_result", result, 8'h00);
    check_eq("rst_din", dp_din, 8'h00);

    // Basic job on requester 0.
    rst_n = 1'b1;
    req   = 2'b01;
    req_a = 16'h0010;
    req_b = 16'h0008;
    run_job("basic", 0, 8'h10, 8'h08, 8'h18, 1, 2'b00);
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_din", dp_din, 8'h00);
    check_eq("idle_result_hold", result, 8'h18);
    check_eq("idle_done_off", done, 2'b00);

    // Overflow wraps silently on requester 1 (pointer now 1).
    req   = 2'b10;
    req_a = 16'hF000;
    req_b = 16'h2000;
    run_job("wrap", 1, 8'hF0, 8'h20, 8'h10, 1, 2'b11);

    // Both requesting: alternate 0,1,0,1 at one job per five cycles.
    req_a = 16'h0301;
    req_b = 16'h0402;
    run_job("rr0", 0, 8'h01, 8'h02, 8'h03, 2, 2'b11);
    run_job("rr1", 1, 8'h03, 8'h04, 8'h07, 2, 2'b11);
    run_job("rr2", 0, 8'h01, 8'h02, 8'h03, 2, 2'b11);
    run_job("rr3", 1, 8'h03, 8'h04, 8'h07, 2, 2'b00);
    @(negedge clk);

    // Three-cycle stall while in ADD.
    req   = 2'b01;
    req_a = 16'h0055;
    req_b = 16'h000A;
    @(negedge clk);
    check_eq("stall_gnt", gnt, 2'b01);
    req = 2'b00;
    @(negedge clk);
    check_eq("stall_add_pre", dp_add, 1'b1);
    add_snap = add_cnt;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_add_low", dp_add, 1'b0);
      check_eq("stall_busy", busy, 1'b1);
      check_eq("stall_done_low", done, 2'b00);
      check_eq("stall_din_hold", dp_din, 8'h0A);
    end
    ena = 1'b1;
    @(negedge clk);
    check_eq("stall_store_nodone", done, 2'b00);
    @(negedge clk);
    check_eq("stall_done", done, 2'b01);
    check_eq("stall_result", result, 8'h5F);
    check_eq("stall_add_once", add_cnt - add_snap, 1);
    @(negedge clk);

    // Reset in the middle of a requester-1 job aborts it.
    req   = 2'b10;
    req_a = 16'h1100;
    req_b = 16'h2200;
    @(negedge clk);
    check_eq("abort_gnt", gnt, 2'b10);
    req = 2'b00;
    @(negedge clk);
    check_eq("abort_in_add", dp_add, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_add", dp_add, 1'b0);
    check_eq("abort_result", result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b11;
    req_a = 16'h1140;
    req_b = 16'h2202;
    run_job("after_abort", 0, 8'h40, 8'h02, 8'h42, 1, 2'b00);
    repeat (3) @(negedge clk);

    check_eq("done_total", done_cnt, 8);
    check_eq("gnt_total", gnt_cnt, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
